// File: rtl/exe_sched_pkg.sv
// rtl/exe_sched_pkg.sv - shared types and constants for the execution-unit scheduler
package exe_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int STATUS_W    = 4;
  localparam int EXE_LATENCY = 1;

  localparam logic [1:0] OP_0 = 2'b00;
  localparam logic [1:0] OP_1 = 2'b01;
  localparam logic [1:0] OP_2 = 2'b10;
  localparam logic [1:0] OP_3 = 2'b11;

endpackage

// File: rtl/exe_unit_sched_rr_arbiter.sv
// rtl/exe_unit_sched_rr_arbiter.sv - round-robin arbiter owning the search pointer (EXE_SCHED_PRIO_EN: requester 0 fixed-high)
import exe_sched_pkg::*;

module rr_arbiter #(
  parameter int R = 4,
  localparam int ID_W = $clog2(R)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [R-1:0]    i_req,
  input  logic            i_adv,
  output logic [R-1:0]    o_gnt_onehot,
  output logic [ID_W-1:0] o_gnt_id
);

`ifdef EXE_SCHED_PRIO_EN
  // With requester 0 outside the rotation the pointer lives in 1..R-1.
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(1);
`else
  localparam logic [ID_W-1:0] PTR_RST = '0;
`endif

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] cand;
  logic            found;
  int              idx;

  // Winner search: first active request at or after ptr, wrapping upward.
  always_comb begin
    found    = 1'b0;
    o_gnt_id = '0;
    idx      = 0;
    cand     = '0;
`ifdef EXE_SCHED_PRIO_EN
    if (i_req[0]) begin
      found = 1'b1;
    end
    for (int i = 0; i < R - 1; i++) begin
      idx  = 1 + ((int'(ptr_q) - 1 + i) % (R - 1));
      cand = ID_W'(idx);
      if (!found && i_req[cand]) begin
        found    = 1'b1;
        o_gnt_id = cand;
      end
    end
`else
    for (int i = 0; i < R; i++) begin
      idx  = (int'(ptr_q) + i) % R;
      cand = ID_W'(idx);
      if (!found && i_req[cand]) begin
        found    = 1'b1;
        o_gnt_id = cand;
      end
    end
`endif
  end

  assign o_gnt_onehot = found ? ({{(R-1){1'b0}}, 1'b1} << o_gnt_id) : '0;

  // Pointer moves one past the winner, but only when the FSM accepts the grant.
  always_comb begin
    ptr_d = ptr_q;
    if (i_adv && found) begin
`ifdef EXE_SCHED_PRIO_EN
      if (o_gnt_id != '0) begin
        ptr_d = (o_gnt_id == ID_W'(R - 1)) ? ID_W'(1) : o_gnt_id + 1'b1;
      end
`else
      ptr_d = (o_gnt_id == ID_W'(R - 1)) ? '0 : o_gnt_id + 1'b1;
`endif
    end
  end

  // Pointer register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= PTR_RST;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/exe_unit_sched.sv
// rtl/exe_unit_sched.sv - shares one 1-cycle execution unit among R requesters (option: EXE_SCHED_PRIO_EN)
import exe_sched_pkg::*;

module exe_unit_sched #(
  parameter int M = 4,
  parameter int N = 2,
  parameter int R = 4,
  localparam int ID_W = $clog2(R)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [R-1:0]        i_req,
  input  logic [R*N-1:0]      i_oper,
  input  logic [R*M-1:0]      i_argA,
  input  logic [R*M-1:0]      i_argB,
  output logic [R-1:0]        o_gnt,
  output logic [N-1:0]        o_exe_oper,
  output logic [M-1:0]        o_exe_argA,
  output logic [M-1:0]        o_exe_argB,
  output logic                o_exe_rsn,
  input  logic [M-1:0]        i_exe_result,
  input  logic [STATUS_W-1:0] i_exe_status,
  output logic                o_busy,
  output logic                o_rsp_valid,
  output logic [ID_W-1:0]     o_rsp_id,
  output logic [M-1:0]        o_result,
  output logic [STATUS_W-1:0] o_status
);

  state_t              state_q, state_d;
  logic [N-1:0]        oper_q, oper_d;
  logic [M-1:0]        arga_q, arga_d;
  logic [M-1:0]        argb_q, argb_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [R-1:0]        gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [M-1:0]        result_q, result_d;
  logic [STATUS_W-1:0] status_q, status_d;

  logic [R-1:0]        arb_onehot;
  logic [ID_W-1:0]     arb_id;
  logic                arb_adv;
  logic [N-1:0]        sel_oper;
  logic [M-1:0]        sel_a;
  logic [M-1:0]        sel_b;

  // Requests are only looked at while the unit is free to take a new op.
  assign arb_adv = (state_q == IDLE) || (state_q == RESP);

  rr_arbiter #(.R(R)) u_arb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req        (i_req),
    .i_adv        (arb_adv),
    .o_gnt_onehot (arb_onehot),
    .o_gnt_id     (arb_id)
  );

  // Pick the winner's operand slice out of the flattened request buses.
  always_comb begin
    sel_oper = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int r = 0; r < R; r++) begin
      if (arb_id == ID_W'(r)) begin
        sel_oper = i_oper[r*N +: N];
        sel_a    = i_argA[r*M +: M];
        sel_b    = i_argB[r*M +: M];
      end
    end
  end

  // Next-state and registered-output computation for the IDLE/ISSUE/WAIT/RESP cycle.
  always_comb begin
    state_d     = state_q;
    oper_d      = oper_q;
    arga_d      = arga_q;
    argb_d      = argb_q;
    id_d        = id_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    result_d    = result_q;
    status_d    = status_q;
    case (state_q)
      IDLE, RESP: begin
        if (|arb_onehot) begin
          state_d = ISSUE;
          oper_d  = sel_oper;
          arga_d  = sel_a;
          argb_d  = sel_b;
          id_d    = arb_id;
          gnt_d   = arb_onehot;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d     = RESP;
        result_d    = i_exe_result;
        status_d    = i_exe_status;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ISSUE) || (state_d == WAIT);
  end

  // Single state/output register bank; reset abandons any in-flight op.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      oper_q      <= '0;
      arga_q      <= '0;
      argb_q      <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      result_q    <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      oper_q      <= oper_d;
      arga_q      <= arga_d;
      argb_q      <= argb_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      result_q    <= result_d;
      status_q    <= status_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_exe_oper  = oper_q;
  assign o_exe_argA  = arga_q;
  assign o_exe_argB  = argb_q;
  assign o_exe_rsn   = ~i_rst;
  assign o_busy      = busy_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_result    = result_q;
  assign o_status    = status_q;

endmodule
